led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
Controller that sequences the 8-LED board display through selectable animation patterns.
- Patterns: centre-out spread, chase, fill, blink.
- Runs each pattern for a programmed number of full cycles, then stops.
- Step rate set by an internal clock prescaler.
- Sits between the board push-button/switch logic and the LED output pins.
- Replaces per-pattern free-running shifters with one start/stop-controlled block.

Parameters:
DIV, 4, clk cycles per pattern step (>=1; DIV=1 steps every clk)
REP_W, 4, width of the repeat-count input

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  level, sampled each clk; begins a run when IDLE
stop  input  1  level, sampled each clk; aborts a run
mode_sel  input  2  pattern: 0 spread, 1 chase, 2 fill, 3 blink
repeat_cnt  input  REP_W  full pattern cycles to run; 0 = run until stop
led  output  8  LED drive, bit 7 = leftmost
busy  output  1  high while in RUN
done  output  1  one-clk pulse when the programmed cycles complete

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, led=8'h00, busy=0, done=0, prescaler=0, remaining=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0 at edge k: latch mode_sel to mode_q and repeat_cnt to remaining, load led with the mode seed, clear prescaler, go RUN.
  - led shows the seed after edge k; busy=1 from edge k.
  - start and stop both high: stay IDLE.
- RUN, prescaler: counts 0..DIV-1 and wraps. A step occurs on the edge where prescaler==DIV-1.
- RUN, first step: occurs DIV edges after edge k.
- Step tables; "end" marks the step that completes one cycle:
  - mode 0 spread: 18->24->42->81->00->end
  - mode 1 chase: 01->02->04->08->10->20->40->80->end
  - mode 2 fill: 01->03->07->0F->1F->3F->7F->FF->end
  - mode 3 blink: FF->00->end
- Cycle end:
  - remaining==0 (infinite): reload seed, stay RUN.
  - remaining==1: go DONE, led=00.
  - Otherwise: remaining-=1, reload seed.
- The reload happens on the end step itself, so no extra cycle is inserted.
- DONE: lasts exactly one clk, with done=1, busy=0, led=00; then IDLE.
- stop=1 in RUN: next edge goes IDLE, led=00, busy=0, no done pulse.
  - stop has priority over a coincident step or cycle end.
- Ignored while in RUN: start, and changes on mode_sel/repeat_cnt.
- Holding start high through DONE re-starts the block from IDLE on the following edge.
- Reset asserted mid-run: immediate clear to reset values; no done pulse.
- Width rule: remaining is REP_W bits and is only decremented when >1, so it never wraps.
- led is registered; no combinational path from any input to led, busy or done.

Decomposition:
- Package led_seq_pkg holds:
  - state encoding (IDLE, RUN, DONE)
  - mode codes (MODE_SPREAD=0, MODE_CHASE=1, MODE_FILL=2, MODE_BLINK=3)
  - seed constants (8'h18, 8'h01, 8'h01, 8'hFF)
  - terminal pattern constants (8'h00, 8'h80, 8'hFF, 8'h00)
- Sub-module led_tick_gen:
  - parameter DIV
  - inputs clk, reset, clr, en; output tick
  - one-clk pulse every DIV enabled cycles
  - clr forces count to 0

Test Plan:
- DIV=2, mode 0, repeat 1, start pulse: led=18 then 24,42,81,00, each held 2 clks -> DONE, done=1 for 1 clk, led=00, busy=0.
- DIV=1, mode 1, repeat 2: led walks 01..80 twice (16 values, 1 clk each) -> done pulse exactly once, on the clk after the second 80.
- DIV=3, mode 3, repeat 0: led FF/00 alternating every 3 clks for 50 clks with no done; stop=1 together with a step -> next edge led=00, busy=0, done never asserts.
- Mode 2 running; change mode_sel to 0 and pulse start mid-run -> sequence stays 01,03,..,FF unchanged.
- DIV=2, mode 1 at led=08: drive reset=0 between clk edges -> led=00, busy=0 immediately, with no clk edge; after release, start -> led=01.
- start=1 and stop=1 together in IDLE -> stays IDLE, led=00, busy=0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_SPREAD = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    // First pattern shown when a cycle begins.
    localparam logic [7:0] SEED_SPREAD = 8'h18;
    localparam logic [7:0] SEED_CHASE  = 8'h01;
    localparam logic [7:0] SEED_FILL   = 8'h01;
    localparam logic [7:0] SEED_BLINK  = 8'hFF;

    // Last pattern of a cycle; the step taken from it ends the cycle.
    localparam logic [7:0] TERM_SPREAD = 8'h00;
    localparam logic [7:0] TERM_CHASE  = 8'h80;
    localparam logic [7:0] TERM_FILL   = 8'hFF;
    localparam logic [7:0] TERM_BLINK  = 8'h00;

    function automatic logic [7:0] mode_seed(input mode_e m);
        case (m)
            MODE_SPREAD: mode_seed = SEED_SPREAD;
            MODE_CHASE:  mode_seed = SEED_CHASE;
            MODE_FILL:   mode_seed = SEED_FILL;
            default:     mode_seed = SEED_BLINK;
        endcase
    endfunction

    function automatic logic [7:0] mode_term(input mode_e m);
        case (m)
            MODE_SPREAD: mode_term = TERM_SPREAD;
            MODE_CHASE:  mode_term = TERM_CHASE;
            MODE_FILL:   mode_term = TERM_FILL;
            default:     mode_term = TERM_BLINK;
        endcase
    endfunction

    // Pattern following cur within a cycle. Spread moves the upper nibble
    // left and the lower nibble right, so 18->24->42->81->00.
    function automatic logic [7:0] next_pattern(input mode_e m, input logic [7:0] cur);
        case (m)
            MODE_SPREAD: next_pattern = {cur[6:4], 1'b0, 1'b0, cur[3:1]};
            MODE_CHASE:  next_pattern = {cur[6:0], 1'b0};
            MODE_FILL:   next_pattern = {cur[6:0], 1'b1};
            default:     next_pattern = ~cur;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control/status bundle between the switch logic and the sequencer.
//
// Signalling: start and stop are levels sampled on every rising clk edge;
// there is no ready/ack. start is honoured only in IDLE (and only when stop
// is low); stop is honoured only in RUN. mode_sel/repeat_cnt are captured
// on the accepting edge and ignored afterwards. busy/done/led/state are
// driven from registers only.
interface led_pattern_sequencer_if #(
    parameter int REP_W = 4
);
    import led_seq_pkg::*;

    logic             start;
    logic             stop;
    logic [1:0]       mode_sel;
    logic [REP_W-1:0] repeat_cnt;
    logic [7:0]       led;
    logic             busy;
    logic             done;
    state_e           state;      // debug view of the controller FSM

    modport master (
        output start, stop, mode_sel, repeat_cnt,
        input  led, busy, done, state
    );

    modport slave (
        input  start, stop, mode_sel, repeat_cnt,
        output led, busy, done, state
    );

endinterface

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: one-clk tick every DIV enabled cycles.
module led_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count 0..DIV-1 while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Start/stop controlled LED animation sequencer with repeat counting.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int REP_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    led_pattern_sequencer_if.slave   bus
);

    state_e           state_q, state_d;
    mode_e            mode_q,  mode_d;
    logic [REP_W-1:0] rem_q,   rem_d;
    logic [7:0]       led_q,   led_d;
    logic             tick;

    // The prescaler is held at zero whenever not running, so the first
    // step lands exactly DIV edges after the start edge.
    led_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != ST_RUN),
        .en    (state_q == ST_RUN),
        .tick  (tick)
    );

    // Next-state and next-pattern logic.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        led_d   = led_q;
        case (state_q)
            ST_IDLE: begin
                led_d = 8'h00;
                if (bus.start && !bus.stop) begin
                    state_d = ST_RUN;
                    mode_d  = mode_e'(bus.mode_sel);
                    rem_d   = bus.repeat_cnt;
                    led_d   = mode_seed(mode_e'(bus.mode_sel));
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    // Abort beats any coincident step or cycle end.
                    state_d = ST_IDLE;
                    led_d   = 8'h00;
                    rem_d   = '0;
                end else if (tick) begin
                    if (led_q == mode_term(mode_q)) begin
                        // Cycle end: reload on this same step, no gap.
                        if (rem_q == '0) begin
                            led_d = mode_seed(mode_q);
                        end else if (rem_q == REP_W'(1)) begin
                            state_d = ST_DONE;
                            led_d   = 8'h00;
                            rem_d   = '0;
                        end else begin
                            rem_d = rem_q - 1'b1;
                            led_d = mode_seed(mode_q);
                        end
                    end else begin
                        led_d = next_pattern(mode_q, led_q);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                led_d   = 8'h00;
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = 8'h00;
                rem_d   = '0;
            end
        endcase
    end

    // State, mode, repeat and LED registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SPREAD;
            rem_q   <= '0;
            led_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            led_q   <= led_d;
        end
    end

    assign bus.led   = led_q;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.state = state_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer at DIV = 1, 2 and 3.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic [1:0] mode_sel;
    logic [3:0] repeat_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic [1:0] mode;
        logic [3:0] rep;
        int         inst;   // which DUT (its DIV value) is compared
        logic [7:0] led;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs: shared inputs, one per DIV ----------------
    led_pattern_sequencer_if #(.REP_W(4)) if1 ();
    led_pattern_sequencer_if #(.REP_W(4)) if2 ();
    led_pattern_sequencer_if #(.REP_W(4)) if3 ();

    assign if1.start = start;  assign if1.stop = stop;
    assign if1.mode_sel = mode_sel;  assign if1.repeat_cnt = repeat_cnt;
    assign if2.start = start;  assign if2.stop = stop;
    assign if2.mode_sel = mode_sel;  assign if2.repeat_cnt = repeat_cnt;
    assign if3.start = start;  assign if3.stop = stop;
    assign if3.mode_sel = mode_sel;  assign if3.repeat_cnt = repeat_cnt;

    led_pattern_sequencer #(.DIV(1), .REP_W(4)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    led_pattern_sequencer #(.DIV(2), .REP_W(4)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    led_pattern_sequencer #(.DIV(3), .REP_W(4)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    logic [7:0] led_m   [1:3];
    logic       busy_m  [1:3];
    logic       done_m  [1:3];
    logic [1:0] state_m [1:3];

    assign led_m[1] = if1.led;  assign busy_m[1] = if1.busy;
    assign done_m[1] = if1.done;  assign state_m[1] = if1.state;
    assign led_m[2] = if2.led;  assign busy_m[2] = if2.busy;
    assign done_m[2] = if2.done;  assign state_m[2] = if2.state;
    assign led_m[3] = if3.led;  assign busy_m[3] = if3.busy;
    assign done_m[3] = if3.done;  assign state_m[3] = if3.state;

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic sp, input logic [1:0] m, input logic [3:0] r);
        start      = st;
        stop       = sp;
        mode_sel   = m;
        repeat_cnt = r;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 2'd0, 4'd0);
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int inst, input logic [7:0] led,
                             input logic busy, input logic done);
        check({tag, " led"},  led_m[inst], led);
        check({tag, " busy"}, {7'd0, busy_m[inst]}, {7'd0, busy});
        check({tag, " done"}, {7'd0, done_m[inst]}, {7'd0, done});
    endtask

    function automatic void add(input logic st, input logic sp, input logic [1:0] m,
                                input logic [3:0] r, input int inst, input logic [7:0] led,
                                input logic busy, input logic done);
        vec_t v;
        v.start = st; v.stop = sp; v.mode = m; v.rep = r;
        v.inst = inst; v.led = led; v.busy = busy; v.done = done;
        vecs.push_back(v);
    endfunction

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            set_in(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].rep);
            cycle();
            check_out($sformatf("%s row%0d", tag, i), vecs[i].inst,
                      vecs[i].led, vecs[i].busy, vecs[i].done);
        end
        vecs.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [8:0] fill;
        logic [7:0] exp_led;

        set_in(1'b0, 1'b0, 2'd0, 4'd0);
        reset = 1'b0;
        #3;
        for (int k = 1; k <= 3; k++) begin
            check_out($sformatf("reset dut%0d", k), k, 8'h00, 1'b0, 1'b0);
            check($sformatf("reset state dut%0d", k), {6'd0, state_m[k]}, 8'd0);
        end
        repeat (2) cycle();
        reset = 1'b1;

        // DIV=2 spread, one cycle: each pattern held 2 clks, then DONE.
        add(1, 0, 2'd0, 4'd1, 2, 8'h18, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h18, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h24, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h24, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h42, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h42, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h81, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h81, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h00, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h00, 1, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h00, 0, 1);
        add(0, 0, 2'd0, 4'd1, 2, 8'h00, 0, 0);
        add(0, 0, 2'd0, 4'd1, 2, 8'h00, 0, 0);
        run_table("spread");
        do_reset();

        // start and stop together in IDLE: no run.
        for (int i = 0; i < 3; i++) add(1, 1, 2'd1, 4'd2, 1, 8'h00, 0, 0);
        add(0, 0, 2'd1, 4'd2, 1, 8'h00, 0, 0);
        run_table("startstop");

        // DIV=1 chase, two cycles; start held through DONE restarts.
        add(1, 0, 2'd1, 4'd2, 1, 8'h01, 1, 0);
        for (int i = 1; i < 16; i++) add(0, 0, 2'd1, 4'd2, 1, 8'h01 << (i % 8), 1, 0);
        add(1, 0, 2'd1, 4'd2, 1, 8'h00, 0, 1);
        add(1, 0, 2'd1, 4'd2, 1, 8'h00, 0, 0);
        add(1, 0, 2'd1, 4'd2, 1, 8'h01, 1, 0);
        add(0, 0, 2'd1, 4'd2, 1, 8'h02, 1, 0);
        run_table("chase");
        do_reset();

        // DIV=3 blink forever, then stop on a step edge.
        set_in(1'b1, 1'b0, 2'd3, 4'd0);
        cycle();
        check_out("blink n0", 3, 8'hFF, 1'b1, 1'b0);
        start = 1'b0;
        for (int n = 1; n <= 53; n++) begin
            cycle();
            exp_led = ((n / 3) % 2 == 1) ? 8'h00 : 8'hFF;
            check_out($sformatf("blink n%0d", n), 3, exp_led, 1'b1, 1'b0);
        end
        stop = 1'b1;
        cycle();
        check_out("blink stop", 3, 8'h00, 1'b0, 1'b0);
        stop = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycle();
            check_out($sformatf("blink after stop %0d", n), 3, 8'h00, 1'b0, 1'b0);
        end
        do_reset();

        // DIV=2 fill; mode change plus start mid-run must be ignored.
        set_in(1'b1, 1'b0, 2'd2, 4'd1);
        cycle();
        check_out("fill n0", 2, 8'h01, 1'b1, 1'b0);
        start = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            if (n == 5) set_in(1'b1, 1'b0, 2'd0, 4'd5);
            if (n == 6) start = 1'b0;
            cycle();
            if (n < 16) begin
                fill = (9'd1 << (n / 2 + 1)) - 9'd1;
                check_out($sformatf("fill n%0d", n), 2, fill[7:0], 1'b1, 1'b0);
            end else if (n == 16) begin
                check_out("fill done", 2, 8'h00, 1'b0, 1'b1);
            end else begin
                check_out("fill idle", 2, 8'h00, 1'b0, 1'b0);
            end
        end
        do_reset();

        // DIV=2 chase, asynchronous reset while showing 08.
        set_in(1'b1, 1'b0, 2'd1, 4'd0);
        cycle();
        check_out("areset n0", 2, 8'h01, 1'b1, 1'b0);
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            cycle();
            check_out($sformatf("areset n%0d", n), 2, 8'h01 << (n / 2), 1'b1, 1'b0);
        end
        #3;
        reset = 1'b0;
        #1;
        check_out("areset mid", 2, 8'h00, 1'b0, 1'b0);
        check("areset state", {6'd0, state_m[2]}, 8'd0);
        repeat (2) cycle();
        reset = 1'b1;
        set_in(1'b1, 1'b0, 2'd1, 4'd0);
        cycle();
        check_out("areset restart", 2, 8'h01, 1'b1, 1'b0);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
